// File: rtl/q_learning_core.sv
// Single-agent Q-learning update engine: per-action Q banks, shift-based alpha/gamma,
// saturating update, reset-driven table clear and valid/ready flow control.
module q_learning_core #(
    parameter int STATE_W     = 6,
    parameter int NUM_ACTIONS = 16,
    parameter int ACT_W       = 4,
    parameter int Q_W         = 16,
    parameter int ALPHA_SHIFT = 2,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ACT_W-1:0]           action,
    input  logic [STATE_W-1:0]         cur_state,
    input  logic [STATE_W-1:0]         next_state,
    input  logic [Q_W-1:0]             reward,
    output logic                       done,
    output logic [Q_W-1:0]             q_new,
    output logic [Q_W-1:0]             q_max,
    output logic [NUM_ACTIONS*Q_W-1:0] q_row,
    output logic                       bad_action
);

    // state    | meaning
    // INIT     | clearing every bank, one address per cycle
    // IDLE     | in_ready=1, waiting for a transition
    // RD_NEXT  | read next_state row from all banks
    // RD_CUR   | register max of next_state row, read cur_state row
    // CALC     | compute saturated new value, register result row
    // WRITE    | write bank[action], done pulse
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RD_NEXT, S_RD_CUR, S_CALC, S_WRITE
    } state_t;

    localparam int EW = Q_W + 3;
    localparam logic [ACT_W:0] NA_LIM = (ACT_W+1)'(NUM_ACTIONS);
    localparam logic signed [EW-1:0] SAT_HI = {{4{1'b0}}, {(Q_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_LO = {{4{1'b1}}, {(Q_W-1){1'b0}}};

    state_t                     state_q, state_d;
    logic [STATE_W-1:0]         init_addr_q, init_addr_d;
    logic [ACT_W-1:0]           act_q, act_d;
    logic [STATE_W-1:0]         cur_q, cur_d;
    logic [STATE_W-1:0]         nxt_q, nxt_d;
    logic [Q_W-1:0]             rew_q, rew_d;
    logic [Q_W-1:0]             max_q, max_d;
    logic                       done_q, done_d;
    logic                       bad_q, bad_d;
    logic [Q_W-1:0]             q_new_q, q_new_d;
    logic [Q_W-1:0]             q_max_q, q_max_d;
    logic [NUM_ACTIONS*Q_W-1:0] q_row_q, q_row_d;

    logic                       wr_en, wr_all;
    logic [ACT_W-1:0]           wr_act;
    logic [STATE_W-1:0]         wr_addr;
    logic [Q_W-1:0]             wr_data;
    logic                       rd_en;
    logic [STATE_W-1:0]         rd_addr;
    logic [NUM_ACTIONS*Q_W-1:0] rd_flat;

    for (genvar g = 0; g < NUM_ACTIONS; g++) begin : g_bank
        logic [Q_W-1:0] mem [2**STATE_W];
        logic [Q_W-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (wr_en && !rst && (wr_all || wr_act == ACT_W'(g))) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_q <= mem[rd_addr];
            end
        end
        assign rd_flat[g*Q_W +: Q_W] = rd_q;
    end

    logic signed [Q_W-1:0] row_max, old_v, new_v;
    logic signed [EW-1:0]  old_x, max_x, rew_x, target_x, delta_x, new_x;
    logic                  bad_v;
    logic [NUM_ACTIONS*Q_W-1:0] row_upd;

    always_comb begin
        row_max = rd_flat[Q_W-1:0];
        for (int i = 1; i < NUM_ACTIONS; i++) begin
            if ($signed(rd_flat[i*Q_W +: Q_W]) > row_max) begin
                row_max = rd_flat[i*Q_W +: Q_W];
            end
        end
    end

    // Update datapath runs in CALC: rd_flat holds the cur_state row there.
    always_comb begin
        bad_v = ({1'b0, act_q} >= NA_LIM);
        old_v = '0;
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            if (act_q == ACT_W'(i)) begin
                old_v = rd_flat[i*Q_W +: Q_W];
            end
        end
        old_x    = {{3{old_v[Q_W-1]}}, old_v};
        max_x    = {{3{max_q[Q_W-1]}}, max_q};
        rew_x    = {{3{rew_q[Q_W-1]}}, rew_q};
        target_x = rew_x + max_x - (max_x >>> GAMMA_SHIFT);
        delta_x  = target_x - old_x;
        new_x    = old_x + (delta_x >>> ALPHA_SHIFT);
        if (new_x > SAT_HI) begin
            new_v = SAT_HI[Q_W-1:0];
        end else if (new_x < SAT_LO) begin
            new_v = SAT_LO[Q_W-1:0];
        end else begin
            new_v = new_x[Q_W-1:0];
        end
        row_upd = rd_flat;
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            if (!bad_v && act_q == ACT_W'(i)) begin
                row_upd[i*Q_W +: Q_W] = new_v;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        act_d       = act_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        rew_d       = rew_q;
        max_d       = max_q;
        done_d      = 1'b0;
        bad_d       = bad_q;
        q_new_d     = q_new_q;
        q_max_d     = q_max_q;
        q_row_d     = q_row_q;
        wr_en       = 1'b0;
        wr_all      = 1'b0;
        wr_act      = act_q;
        wr_addr     = cur_q;
        wr_data     = q_new_q;
        rd_en       = 1'b0;
        rd_addr     = nxt_q;
        case (state_q)
            S_INIT: begin
                wr_en       = 1'b1;
                wr_all      = 1'b1;
                wr_addr     = init_addr_q;
                wr_data     = '0;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == {STATE_W{1'b1}}) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    act_d   = action;
                    cur_d   = cur_state;
                    nxt_d   = next_state;
                    rew_d   = reward;
                    state_d = S_RD_NEXT;
                end
            end
            S_RD_NEXT: begin
                rd_en   = 1'b1;
                rd_addr = nxt_q;
                state_d = S_RD_CUR;
            end
            S_RD_CUR: begin
                max_d   = row_max;
                rd_en   = 1'b1;
                rd_addr = cur_q;
                state_d = S_CALC;
            end
            S_CALC: begin
                bad_d   = bad_v;
                q_new_d = bad_v ? '0 : new_v;
                q_max_d = max_q;
                q_row_d = row_upd;
                done_d  = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                wr_en   = !bad_q;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_addr_q <= '0;
            act_q       <= '0;
            cur_q       <= '0;
            nxt_q       <= '0;
            rew_q       <= '0;
            max_q       <= '0;
            done_q      <= 1'b0;
            bad_q       <= 1'b0;
            q_new_q     <= '0;
            q_max_q     <= '0;
            q_row_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            act_q       <= act_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            rew_q       <= rew_d;
            max_q       <= max_d;
            done_q      <= done_d;
            bad_q       <= bad_d;
            q_new_q     <= q_new_d;
            q_max_q     <= q_max_d;
            q_row_q     <= q_row_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign done       = done_q;
    assign bad_action = bad_q;
    assign q_new      = q_new_q;
    assign q_max      = q_max_q;
    assign q_row      = q_row_q;

endmodule
